recv_ctrl_uart: RTL

Command-frame receiver for the UART link, the return direction of the telemetry transmit path. Reads bytes from the uart RX FIFO (non-showahead, 8-bit), finds header, validates length and checksum, and exposes the decoded command and a shadowed payload buffer. A baud-change command drives latch_baud/baud_word directly. Runs in the clk (110.592 MHz) domain beside trans_ctrl_uart1.

---
 rtl/recv_ctrl_pkg.sv | 28 ++
 rtl/uart_byte_fetch.sv | 39 +++
 rtl/recv_ctrl_uart.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/recv_ctrl_pkg.sv
// Shared definitions for the UART command-frame receiver.
//   - Frame header bytes and command codes
//   - Default payload depth
//   - Frame-parser state encoding
//   - Saturating 8-bit increment helper for error counters
package recv_ctrl_pkg;

  localparam int unsigned MaxLenDefault  = 16;
  localparam int unsigned TimeoutDefault = 110592;  // 1 ms at 110.592 MHz

  localparam logic [7:0] Hdr0Default    = 8'hEB;
  localparam logic [7:0] Hdr1Default    = 8'h90;
  localparam logic [7:0] CmdBaudDefault = 8'h01;

  typedef enum logic [2:0] {
    StH0,
    StH1,
    StCmd,
    StLen,
    StData,
    StChk
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_fetch.sv
// Read handshake for a non-showahead byte FIFO.
//   clk_i / rst_ni   : clock, synchronous active-low reset
//   ena_i            : allow new reads (a read already issued still completes)
//   fifo_empty_i     : FIFO empty flag
//   fifo_ren_o       : FIFO read strobe, never asserted while empty
//   fifo_rdata_i     : FIFO data, valid the cycle after the strobe
//   byte_o/byte_vld_o: fetched byte and its one-cycle valid
// At most one byte every two cycles: a new strobe waits for the pending one to land.
module uart_byte_fetch (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ena_i,
  input  logic       fifo_empty_i,
  output logic       fifo_ren_o,
  input  logic [7:0] fifo_rdata_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o
);

  logic rd_pend_d, rd_pend_q;

  always_comb begin
    // Gated by reset so no byte is pulled from the FIFO while it would be discarded.
    fifo_ren_o = rst_ni & ena_i & ~fifo_empty_i & ~rd_pend_q;
    rd_pend_d  = fifo_ren_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  assign byte_o     = fifo_rdata_i;
  assign byte_vld_o = rd_pend_q;

endmodule

// File: rtl/recv_ctrl_uart.sv
// UART command-frame receiver.
// Frame: HDR0 HDR1 CMD LEN PAYLOAD[LEN] CHK, CHK = 8-bit sum of CMD, LEN and payload.
//   clk, rst (sync active-low), ena       : clock, reset, fetch/timeout enable
//   rx_fifo_empty/ren/rdata               : non-showahead RX FIFO read port
//   cmd_valid, cmd_code, cmd_len          : pulse and header of last good frame
//   cmd_raddr -> cmd_rdata                : combinational read of the shadow payload buffer
//   latch_baud, baud_word                 : baud-change command result
//   chk_err_cnt, frm_err                  : saturating checksum error count, error pulse
module recv_ctrl_uart
  import recv_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN  = MaxLenDefault,
  parameter int unsigned TIMEOUT  = TimeoutDefault,
  parameter logic [7:0]  HDR0     = Hdr0Default,
  parameter logic [7:0]  HDR1     = Hdr1Default,
  parameter logic [7:0]  CMD_BAUD = CmdBaudDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       rx_fifo_empty,
  output logic                       rx_fifo_ren,
  input  logic [7:0]                 rx_fifo_rdata,
  output logic                       cmd_valid,
  output logic [7:0]                 cmd_code,
  output logic [7:0]                 cmd_len,
  input  logic [$clog2(MAX_LEN)-1:0] cmd_raddr,
  output logic [7:0]                 cmd_rdata,
  output logic                       latch_baud,
  output logic [15:0]                baud_word,
  output logic [7:0]                 chk_err_cnt,
  output logic                       frm_err
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  logic [7:0] rx_byte;
  logic       byte_vld;

  uart_byte_fetch u_fetch (
    .clk_i        (clk),
    .rst_ni       (rst),
    .ena_i        (ena),
    .fifo_empty_i (rx_fifo_empty),
    .fifo_ren_o   (rx_fifo_ren),
    .fifo_rdata_i (rx_fifo_rdata),
    .byte_o       (rx_byte),
    .byte_vld_o   (byte_vld)
  );

  rx_state_e     state_d, state_q;
  logic [7:0]    idx_d, idx_q;
  logic [7:0]    len_d, len_q;
  logic [7:0]    code_d, code_q;
  logic [7:0]    sum_d, sum_q;
  logic [TW-1:0] tmo_d, tmo_q;

  logic          cmd_valid_d, cmd_valid_q;
  logic          frm_err_d, frm_err_q;
  logic          latch_baud_d, latch_baud_q;
  logic [7:0]    cmd_code_d, cmd_code_q;
  logic [7:0]    cmd_len_d, cmd_len_q;
  logic [15:0]   baud_word_d, baud_word_q;
  logic [7:0]    chk_err_cnt_d, chk_err_cnt_q;

  // Payload is assembled in work_buf and only copied to out_buf on a good checksum,
  // so readers of out_buf never see a partially received frame.
  logic [7:0]    work_buf_q [MAX_LEN];
  logic [7:0]    out_buf_q  [MAX_LEN];
  logic          work_we;
  logic          out_load;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    code_d        = code_q;
    sum_d         = sum_q;
    tmo_d         = tmo_q;
    cmd_valid_d   = 1'b0;
    frm_err_d     = 1'b0;
    latch_baud_d  = 1'b0;
    cmd_code_d    = cmd_code_q;
    cmd_len_d     = cmd_len_q;
    baud_word_d   = baud_word_q;
    chk_err_cnt_d = chk_err_cnt_q;
    work_we       = 1'b0;
    out_load      = 1'b0;

    if (byte_vld) begin
      // A consumed byte always wins over a coincident timeout.
      tmo_d = '0;
      unique case (state_q)
        StH0: begin
          if (rx_byte == HDR0) state_d = StH1;
        end
        StH1: begin
          if (rx_byte == HDR1) begin
            state_d = StCmd;
          end else if (rx_byte != HDR0) begin
            state_d = StH0;
          end
        end
        StCmd: begin
          code_d  = rx_byte;
          sum_d   = rx_byte;
          state_d = StLen;
        end
        StLen: begin
          len_d = rx_byte;
          sum_d = sum_q + rx_byte;
          if ({24'd0, rx_byte} > MAX_LEN) begin
            frm_err_d = 1'b1;
            state_d   = StH0;
          end else if (rx_byte == 8'd0) begin
            state_d = StChk;
          end else begin
            idx_d   = 8'd0;
            state_d = StData;
          end
        end
        StData: begin
          work_we = 1'b1;
          sum_d   = sum_q + rx_byte;
          if (idx_q == len_q - 8'd1) begin
            state_d = StChk;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        StChk: begin
          if (rx_byte == sum_q) begin
            out_load    = 1'b1;
            cmd_valid_d = 1'b1;
            cmd_code_d  = code_q;
            cmd_len_d   = len_q;
            if (code_q == CMD_BAUD && len_q == 8'd2) begin
              latch_baud_d = 1'b1;
              baud_word_d  = {work_buf_q[0], work_buf_q[1]};
            end
          end else begin
            frm_err_d     = 1'b1;
            chk_err_cnt_d = sat_inc8(chk_err_cnt_q);
          end
          state_d = StH0;
        end
        default: state_d = StH0;
      endcase
    end else if (state_q == StH0) begin
      tmo_d = '0;
    end else if (ena) begin
      if (tmo_q == TmoLast) begin
        tmo_d     = '0;
        frm_err_d = 1'b1;
        state_d   = StH0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StH0;
      idx_q         <= '0;
      len_q         <= '0;
      code_q        <= '0;
      sum_q         <= '0;
      tmo_q         <= '0;
      cmd_valid_q   <= 1'b0;
      frm_err_q     <= 1'b0;
      latch_baud_q  <= 1'b0;
      cmd_code_q    <= '0;
      cmd_len_q     <= '0;
      baud_word_q   <= '0;
      chk_err_cnt_q <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        work_buf_q[i] <= '0;
        out_buf_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      code_q        <= code_d;
      sum_q         <= sum_d;
      tmo_q         <= tmo_d;
      cmd_valid_q   <= cmd_valid_d;
      frm_err_q     <= frm_err_d;
      latch_baud_q  <= latch_baud_d;
      cmd_code_q    <= cmd_code_d;
      cmd_len_q     <= cmd_len_d;
      baud_word_q   <= baud_word_d;
      chk_err_cnt_q <= chk_err_cnt_d;
      if (work_we) work_buf_q[idx_q[AW-1:0]] <= rx_byte;
      if (out_load) begin
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
          out_buf_q[i] <= work_buf_q[i];
        end
      end
    end
  end

  always_comb begin
    cmd_rdata = 8'd0;
    if (32'(cmd_raddr) < MAX_LEN) cmd_rdata = out_buf_q[cmd_raddr];
  end

  assign cmd_valid   = cmd_valid_q;
  assign frm_err     = frm_err_q;
  assign latch_baud  = latch_baud_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_len     = cmd_len_q;
  assign baud_word   = baud_word_q;
  assign chk_err_cnt = chk_err_cnt_q;

endmodule
